t1_run_supervisor: RTL and testbench

//  Synthesisable, parametrised successor to the cosim clock/watchdog testbench logic.
//  - Sequences DUT reset release.
//  - Runs NUM_CH independent retire watchdogs plus a global cycle timeout.
//  - Gates the waveform-dump window.
//  - Reports a single run status: running / done / fault code.

---
 rtl/t1_supervisor_pkg.sv | 16 +
 rtl/t1_watchdog_channel.sv | 57 +++++
 rtl/t1_run_supervisor.sv | 167 ++++++++++++++++
 tb/tb_t1_run_supervisor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/t1_supervisor_pkg.sv
// Shared types and status codes for the run supervisor.
package t1_supervisor_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] ST_RUNNING        = 8'd0;
  localparam logic [7:0] ST_DONE           = 8'd255;
  localparam logic [7:0] ST_CH_TIMEOUT     = 8'd1;
  localparam logic [7:0] ST_GLOBAL_TIMEOUT = 8'd2;

endpackage

// File: rtl/t1_watchdog_channel.sv
// One retire watchdog: idle counter, sticky done, timeout flag.
// Optional max-gap statistic under T1_SUPERVISOR_GAP_STATS_EN.
module t1_watchdog_channel
  import t1_supervisor_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_active,
  input  logic             i_heartbeat,
  input  logic             i_done,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done,
  output logic             o_timeout
`ifdef T1_SUPERVISOR_GAP_STATS_EN
  ,
  output logic [CNT_W-1:0] o_max_gap
`endif
);

  logic [CNT_W-1:0] r_idle;
  logic             r_done;

  // A heartbeat landing on the limit cycle rescues the channel.
  assign o_timeout = i_active && !i_heartbeat && (i_limit != '0) && (r_idle == i_limit);
  // Same-cycle done counts, so finish can beat a coincident timeout.
  assign o_done    = r_done | i_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle <= '0;
      r_done <= 1'b0;
    end else if (i_run) begin
      r_done <= o_done;
      if (!i_active || i_heartbeat)
        r_idle <= '0;
      else if (r_idle != '1)
        r_idle <= r_idle + 1'b1;
    end
  end

`ifdef T1_SUPERVISOR_GAP_STATS_EN
  logic [CNT_W-1:0] r_max_gap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_max_gap <= '0;
    else if (i_run && (i_heartbeat || o_timeout) && (r_idle > r_max_gap))
      r_max_gap <= r_idle;
  end

  assign o_max_gap = r_max_gap;
`endif

endmodule

// File: rtl/t1_run_supervisor.sv
// Cosim/emulation run supervisor: DUT reset sequencing, watchdogs, dump window, run status.
// Define T1_SUPERVISOR_GAP_STATS_EN to add max_gap / max_gap_ch outputs.
module t1_run_supervisor
  import t1_supervisor_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int CYC_W     = 64,
  parameter int RESET_CYC = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic [CYC_W-1:0]  cfg_global_timeout,
  input  logic [CYC_W-1:0]  cfg_dump_start,
  input  logic [CYC_W-1:0]  cfg_dump_end,
  input  logic [NUM_CH-1:0] ch_active,
  input  logic [NUM_CH-1:0] ch_heartbeat,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic              tb_done,
  output logic              dut_reset,
  output logic [CYC_W-1:0]  cycle,
  output logic              dump_en,
  output logic [7:0]        status,
  output logic [3:0]        fault_ch
`ifdef T1_SUPERVISOR_GAP_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] max_gap,
  output logic [3:0]              max_gap_ch
`endif
);

  localparam int HOLD_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  state_t            r_state, w_state_n;
  logic [HOLD_W-1:0] r_hold;
  logic [CYC_W-1:0]  r_cycle, w_cycle_n;
  logic [7:0]        r_status, w_status_n;
  logic [3:0]        r_fault_ch, w_fault_ch_n, w_low_ch;
  logic              r_dump, w_dump_n;
  logic              r_tb_done;
  logic [CNT_W-1:0]  r_cfg_timeout;
  logic [CYC_W-1:0]  r_cfg_gto, r_cfg_dstart, r_cfg_dend;
  logic [CYC_W-1:0]  w_dstart, w_dend;
  logic [NUM_CH-1:0] w_ch_done, w_ch_to;
  logic              w_run, w_cap, w_finish, w_any_to, w_glob_to;

  assign w_run = (r_state == RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    t1_watchdog_channel #(.CNT_W(CNT_W)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .i_run       (w_run),
      .i_active    (ch_active[g]),
      .i_heartbeat (ch_heartbeat[g]),
      .i_done      (ch_done[g]),
      .i_limit     (r_cfg_timeout),
      .o_done      (w_ch_done[g]),
      .o_timeout   (w_ch_to[g])
`ifdef T1_SUPERVISOR_GAP_STATS_EN
      ,
      .o_max_gap   (max_gap[g*CNT_W +: CNT_W])
`endif
    );
  end

  assign w_finish  = (&w_ch_done) && (r_tb_done || tb_done);
  assign w_any_to  = |w_ch_to;
  assign w_glob_to = (r_cfg_gto != '0) && (r_cycle == r_cfg_gto);

  always_comb begin
    w_low_ch = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_ch_to[i]) w_low_ch = 4'(i);
  end

  always_comb begin
    w_state_n    = r_state;
    w_status_n   = r_status;
    w_fault_ch_n = r_fault_ch;
    w_cap        = 1'b0;
    case (r_state)
      HOLD: begin
        if (r_hold == HOLD_W'(RESET_CYC - 1)) begin
          w_state_n = RUN;
          w_cap     = 1'b1;
        end
      end
      RUN: begin
        if (w_finish) begin
          w_state_n  = DONE;
          w_status_n = ST_DONE;
        end else if (w_any_to) begin
          w_state_n    = FAULT;
          w_status_n   = ST_CH_TIMEOUT;
          w_fault_ch_n = w_low_ch;
        end else if (w_glob_to) begin
          w_state_n  = FAULT;
          w_status_n = ST_GLOBAL_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  assign w_cycle_n = (w_run && (r_cycle != '1)) ? r_cycle + 1'b1 : r_cycle;

  // dump_en is registered from next-cycle values so it lines up with cycle;
  // on the HOLD->RUN edge the live cfg inputs are the ones being captured.
  assign w_dstart = (r_state == HOLD) ? cfg_dump_start : r_cfg_dstart;
  assign w_dend   = (r_state == HOLD) ? cfg_dump_end   : r_cfg_dend;
  assign w_dump_n = (w_state_n == RUN) && (w_cycle_n >= w_dstart) &&
                    ((w_dend == '0) || (w_cycle_n < w_dend));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= HOLD;
      r_hold        <= '0;
      r_cycle       <= '0;
      r_status      <= ST_RUNNING;
      r_fault_ch    <= '0;
      r_dump        <= 1'b0;
      r_tb_done     <= 1'b0;
      r_cfg_timeout <= '0;
      r_cfg_gto     <= '0;
      r_cfg_dstart  <= '0;
      r_cfg_dend    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_status   <= w_status_n;
      r_fault_ch <= w_fault_ch_n;
      r_cycle    <= w_cycle_n;
      r_dump     <= w_dump_n;
      if (r_state == HOLD) r_hold <= r_hold + 1'b1;
      if (w_run) r_tb_done <= r_tb_done || tb_done;
      if (w_cap) begin
        r_cfg_timeout <= cfg_timeout;
        r_cfg_gto     <= cfg_global_timeout;
        r_cfg_dstart  <= cfg_dump_start;
        r_cfg_dend    <= cfg_dump_end;
      end
    end
  end

  assign dut_reset = (r_state == HOLD);
  assign cycle     = r_cycle;
  assign dump_en   = r_dump;
  assign status    = r_status;
  assign fault_ch  = r_fault_ch;

`ifdef T1_SUPERVISOR_GAP_STATS_EN
  logic [CNT_W-1:0] w_best;

  always_comb begin
    w_best     = '0;
    max_gap_ch = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (max_gap[i*CNT_W +: CNT_W] > w_best) begin
        w_best     = max_gap[i*CNT_W +: CNT_W];
        max_gap_ch = 4'(i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_t1_run_supervisor.sv
// Directed bench for t1_run_supervisor (default build, no gap stats).
module tb_t1_run_supervisor;
  localparam int NUM_CH = 4, CNT_W = 32, CYC_W = 64, RESET_CYC = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [CNT_W-1:0]  cfg_timeout;
  logic [CYC_W-1:0]  cfg_global_timeout, cfg_dump_start, cfg_dump_end;
  logic [NUM_CH-1:0] ch_active, ch_heartbeat, ch_done;
  logic              tb_done;
  logic              dut_reset, dump_en;
  logic [CYC_W-1:0]  cycle;
  logic [7:0]        status;
  logic [3:0]        fault_ch;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hold   = 0;
  int hold_bad = 0;

  always #5 clock = ~clock;

  t1_run_supervisor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W), .RESET_CYC(RESET_CYC)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cfg_timeout        (cfg_timeout),
    .cfg_global_timeout (cfg_global_timeout),
    .cfg_dump_start     (cfg_dump_start),
    .cfg_dump_end       (cfg_dump_end),
    .ch_active          (ch_active),
    .ch_heartbeat       (ch_heartbeat),
    .ch_done            (ch_done),
    .tb_done            (tb_done),
    .dut_reset          (dut_reset),
    .cycle              (cycle),
    .dump_en            (dump_en),
    .status             (status),
    .fault_ch           (fault_ch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Hold in reset with a fresh configuration.
  task automatic setup(input logic [CNT_W-1:0] to, input logic [CYC_W-1:0] gto,
                       input logic [CYC_W-1:0] ds, input logic [CYC_W-1:0] de,
                       input logic [NUM_CH-1:0] act);
    reset              = 1'b0;
    cfg_timeout        = to;
    cfg_global_timeout = gto;
    cfg_dump_start     = ds;
    cfg_dump_end       = de;
    ch_active          = act;
    ch_heartbeat       = '0;
    ch_done            = '0;
    tb_done            = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Release reset and walk through HOLD; ends on the negedge of RUN cycle 0.
  task automatic release_run();
    reset    = 1'b1;
    hold     = 0;
    hold_bad = 0;
    while (dut_reset && hold < 32) begin
      if (cycle != 0 || dump_en !== 1'b0) hold_bad++;
      hold++;
      @(negedge clock);
    end
    cyc = 0;
  endtask

  task automatic finish_pulse();
    ch_done = '1;
    tb_done = 1'b1;
    step();
    ch_done = '0;
    tb_done = 1'b0;
  endtask

  initial begin
    // 1. reset state and HOLD length
    setup(100, 0, 0, 0, 4'b0001);
    check("rst_dut_reset", dut_reset, 1);
    check("rst_cycle",     cycle, 0);
    check("rst_status",    status, 0);
    check("rst_fault_ch",  fault_ch, 0);
    check("rst_dump_en",   dump_en, 0);
    release_run();
    check("hold_len",      hold, RESET_CYC);
    check("hold_quiet",    hold_bad, 0);
    check("run0_dut_reset", dut_reset, 0);
    check("run0_cycle",    cycle, 0);
    step();
    check("run1_cycle",    cycle, 1);

    // 2. healthy run, heartbeats every 50, tb_done early, all ch_done at 500
    while (cyc < 500) begin
      ch_heartbeat = (cyc % 50 == 49) ? 4'b0001 : 4'b0000;
      tb_done      = (cyc == 300);
      step();
    end
    ch_heartbeat = '0;
    tb_done      = 1'b0;
    check("t2_pre_status", status, 0);
    check("t2_pre_cycle",  cycle, 500);
    finish_pulse();
    check("t2_status",     status, 255);
    check("t2_fault_ch",   fault_ch, 0);
    check("t2_dut_reset",  dut_reset, 0);
    repeat (3) step();
    check("t2_cycle_frozen", cycle, 501);
    check("t2_status_hold",  status, 255);

    // 3. single channel timeout
    setup(100, 0, 0, 0, 4'b0100);
    release_run();
    run_to(100);
    check("t3_pre_status", status, 0);
    step();
    check("t3_status",     status, 1);
    check("t3_fault_ch",   fault_ch, 2);
    repeat (2) step();
    check("t3_status_hold", status, 1);
    check("t3_cycle_frozen", cycle, 101);

    // 3b. two channels together: lowest index reported
    setup(100, 0, 0, 0, 4'b1010);
    release_run();
    run_to(101);
    check("t3b_status",   status, 1);
    check("t3b_fault_ch", fault_ch, 1);

    // 3c. heartbeat on the limit cycle rescues; next gap times out
    setup(100, 0, 0, 0, 4'b0001);
    release_run();
    run_to(100);
    ch_heartbeat = 4'b0001;
    step();
    ch_heartbeat = '0;
    check("t3c_rescued", status, 0);
    run_to(201);
    check("t3c_pre_status", status, 0);
    step();
    check("t3c_status",   status, 1);
    check("t3c_fault_ch", fault_ch, 0);

    // 4. global timeout coincident with finish: finish wins
    setup(0, 1000, 0, 0, 4'b0000);
    release_run();
    run_to(999);
    check("t4_pre_status", status, 0);
    step();
    check("t4_cycle", cycle, 1000);
    finish_pulse();
    check("t4_status", status, 255);

    // 4b. global timeout alone
    setup(0, 1000, 0, 0, 4'b0000);
    release_run();
    run_to(1000);
    check("t4b_pre_status", status, 0);
    step();
    check("t4b_status",   status, 2);
    check("t4b_fault_ch", fault_ch, 0);

    // 5. dump window 20..39
    setup(0, 0, 20, 40, 4'b0000);
    release_run();
    while (cyc <= 50) begin
      check($sformatf("t5_dump_c%0d", cyc), dump_en, (cyc >= 20 && cyc < 40) ? 1 : 0);
      step();
    end

    // 5b. start=0, end=0: whole RUN phase, off once terminal
    setup(0, 0, 0, 0, 4'b0000);
    release_run();
    while (cyc <= 30) begin
      check($sformatf("t5b_dump_c%0d", cyc), dump_en, 1);
      step();
    end
    finish_pulse();
    check("t5b_status",  status, 255);
    check("t5b_dump_off", dump_en, 0);

    // 5c. end <= start never dumps
    setup(0, 0, 30, 30, 4'b0000);
    release_run();
    while (cyc <= 50) begin
      check($sformatf("t5c_dump_c%0d", cyc), dump_en, 0);
      step();
    end

    // 6. mid-run async reset, then a clean re-run
    setup(0, 0, 0, 0, 4'b0000);
    release_run();
    run_to(300);
    check("t6_cycle_pre", cycle, 300);
    reset = 1'b0;
    #1;
    check("t6_async_dut_reset", dut_reset, 1);
    check("t6_async_cycle",     cycle, 0);
    check("t6_async_status",    status, 0);
    check("t6_async_dump",      dump_en, 0);
    @(negedge clock);
    release_run();
    check("t6_hold_len",  hold, RESET_CYC);
    check("t6_hold_quiet", hold_bad, 0);
    run_to(10);
    check("t6_cycle", cycle, 10);
    finish_pulse();
    check("t6_status", status, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
